// File: rtl/bridge_pkg.sv
// Shared definitions for the UART bridge: ASCII framing constants, receive FSM states
// and hex/nibble conversion helpers.
package bridge_pkg;

  localparam logic [7:0] AsciiR  = 8'h52;
  localparam logic [7:0] AsciiW  = 8'h57;
  localparam logic [7:0] AsciiCr = 8'h0D;
  localparam logic [7:0] AsciiLf = 8'h0A;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StEol
  } rx_state_e;

  // Returns {is_hex, nibble}; nibble is 0 when the character is not a hex digit.
  function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
    logic [7:0] d;
    d = 8'h00;
    if (c >= 8'h30 && c <= 8'h39) begin
      d = c - 8'h30;
      return {1'b1, d[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      d = c - 8'h37;
      return {1'b1, d[3:0]};
    end else if (c >= 8'h61 && c <= 8'h66) begin
      d = c - 8'h57;
      return {1'b1, d[3:0]};
    end
    return 5'b0_0000;
  endfunction

  function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/bridge_rx.sv
// Host-to-FPGA half of the UART bridge: parses "R<addr>" / "W<addr><data>" ASCII frames
// terminated by CR or LF into single-cycle bus requests.
module bridge_rx
  import bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            data_i,
  input  logic                  valid_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  rw_o,
  output logic                  valid_o
);

  localparam int unsigned AddrNib = ADDR_WIDTH / 4;
  localparam int unsigned DataNib = DATA_WIDTH / 4;
  localparam int unsigned MaxNib  = (AddrNib > DataNib) ? AddrNib : DataNib;
  localparam int unsigned CntW    = $clog2(MaxNib + 1);

  rx_state_e             state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_sr_q, addr_sr_d;
  logic [DATA_WIDTH-1:0] data_sr_q, data_sr_d;
  logic                  is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  rw_d;
  logic                  valid_d;

  logic [4:0] hex;
  logic       is_hex;
  logic [3:0] nib;
  logic       is_start;
  logic       is_term;

  always_comb begin
    hex      = hex_to_nibble(data_i);
    is_hex   = hex[4];
    nib      = hex[3:0];
    is_start = (data_i == AsciiR) || (data_i == AsciiW);
    is_term  = (data_i == AsciiCr) || (data_i == AsciiLf);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_sr_d  = addr_sr_q;
    data_sr_d  = data_sr_q;
    is_write_d = is_write_q;
    addr_d     = addr_o;
    data_d     = data_o;
    rw_d       = rw_o;
    valid_d    = 1'b0;

    if (valid_i) begin
      if (is_start) begin
        // A frame start restarts parsing from any state.
        is_write_d = (data_i == AsciiW);
        cnt_d      = '0;
        addr_sr_d  = '0;
        data_sr_d  = '0;
        state_d    = StAddr;
      end else begin
        unique case (state_q)
          StIdle: ;
          StAddr: begin
            if (is_hex) begin
              addr_sr_d = (addr_sr_q << 4) | ADDR_WIDTH'(nib);
              if (cnt_q == CntW'(AddrNib - 1)) begin
                cnt_d   = '0;
                state_d = is_write_q ? StData : StEol;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end else begin
              state_d = StIdle;
            end
          end
          StData: begin
            if (is_hex) begin
              data_sr_d = (data_sr_q << 4) | DATA_WIDTH'(nib);
              if (cnt_q == CntW'(DataNib - 1)) begin
                cnt_d   = '0;
                state_d = StEol;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end else begin
              state_d = StIdle;
            end
          end
          StEol: begin
            if (is_term) begin
              addr_d  = addr_sr_q;
              data_d  = is_write_q ? data_sr_q : '0;
              rw_d    = is_write_q;
              valid_d = 1'b1;
            end
            state_d = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_sr_q  <= '0;
      data_sr_q  <= '0;
      is_write_q <= 1'b0;
      addr_o     <= '0;
      data_o     <= '0;
      rw_o       <= 1'b0;
      valid_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_sr_q  <= addr_sr_d;
      data_sr_q  <= data_sr_d;
      is_write_q <= is_write_d;
      addr_o     <= addr_d;
      data_o     <= data_d;
      rw_o       <= rw_d;
      valid_o    <= valid_d;
    end
  end

endmodule

// File: tb/tb_bridge_rx.sv
// Self-checking bench for bridge_rx: byte-level frame stimulus with a scoreboard of
// expected requests compared against each valid_o pulse.
module tb_bridge_rx;

  logic        clk;
  logic        rst;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [15:0] addr_o;
  logic [15:0] data_o;
  logic        rw_o;
  logic        valid_o;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        rw;
  } req_t;

  req_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pulses = 0;

  bridge_rx #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .data_i (data_i),
    .valid_i(valid_i),
    .addr_o (addr_o),
    .data_o (data_o),
    .rw_o   (rw_o),
    .valid_o(valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Byte is presented for one cycle starting at a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    data_i  = b;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    data_i  = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_str(input string s, input int max_gap);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [15:0] d, input logic rw);
    req_t r;
    r.addr = a;
    r.data = d;
    r.rw   = rw;
    exp_q.push_back(r);
  endtask

  always @(negedge clk) begin
    if (!rst && valid_o) begin
      req_t e;
      n_pulses++;
      check_eq("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("addr", 32'(addr_o), 32'(e.addr));
        check_eq("data", 32'(data_o), 32'(e.data));
        check_eq("rw", 32'(rw_o), 32'(e.rw));
      end
    end
  end

  initial begin
    rst     = 1'b1;
    data_i  = 8'h00;
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_addr", 32'(addr_o), 32'd0);
    check_eq("reset_data", 32'(data_o), 32'd0);
    check_eq("reset_rw", 32'(rw_o), 32'd0);
    check_eq("reset_valid", 32'(valid_o), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: simple read, valid_o the cycle after the terminator
    push_exp(16'h1234, 16'h0000, 1'b0);
    send_str("R1234\r", 0);
    check_eq("t1_latency", 32'(valid_o), 32'd1);
    @(negedge clk);
    check_eq("t1_single_pulse", 32'(valid_o), 32'd0);
    check_eq("t1_pulses", 32'(n_pulses), 32'd1);

    // 2: lowercase hex write with CRLF, LF absorbed
    push_exp(16'h00FF, 16'hBEEF, 1'b1);
    send_str("W00FFbeef\r\n", 0);
    repeat (3) @(negedge clk);
    check_eq("t2_pulses", 32'(n_pulses), 32'd2);

    // 3: bad digit drops frame, next frame still decodes
    send_str("R12G4\r", 0);
    push_exp(16'h5678, 16'h0000, 1'b0);
    send_str("R5678\n", 0);
    repeat (3) @(negedge clk);
    check_eq("t3_pulses", 32'(n_pulses), 32'd3);

    // 4: restart mid-frame, then extra digit drops and outputs hold
    push_exp(16'h0001, 16'hABCD, 1'b1);
    send_str("R12W0001ABCD\r", 0);
    send_str("R12345\r", 0);
    repeat (3) @(negedge clk);
    check_eq("t4_pulses", 32'(n_pulses), 32'd4);
    check_eq("t4_hold_addr", 32'(addr_o), 32'h0001);
    check_eq("t4_hold_data", 32'(data_o), 32'hABCD);
    check_eq("t4_hold_rw", 32'(rw_o), 32'd1);

    // 5: asynchronous reset mid-frame discards the frame
    send_str("W1234AB", 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #6 rst = 1'b0;
    check_eq("t5_rst_addr", 32'(addr_o), 32'd0);
    check_eq("t5_rst_data", 32'(data_o), 32'd0);
    check_eq("t5_rst_rw", 32'(rw_o), 32'd0);
    send_str("CD\r", 0);
    repeat (3) @(negedge clk);
    check_eq("t5_no_pulse", 32'(n_pulses), 32'd4);
    check_eq("t5_post_addr", 32'(addr_o), 32'd0);
    push_exp(16'h0042, 16'h0000, 1'b0);
    send_str("R0042\r", 0);
    repeat (3) @(negedge clk);
    check_eq("t5_pulses", 32'(n_pulses), 32'd5);

    // 6: random frames with mixed case, terminators and idle gaps
    for (int k = 0; k < 10; k++) begin
      logic        rw;
      logic [15:0] a;
      logic [15:0] d;
      string       s;
      string       term;
      rw = 1'(($urandom_range(0, 1)));
      a  = 16'($urandom);
      d  = 16'($urandom);
      if (rw) begin
        s = ($urandom_range(0, 1) != 0) ? $sformatf("W%04X%04X", a, d)
                                        : $sformatf("W%04x%04x", a, d);
      end else begin
        s = ($urandom_range(0, 1) != 0) ? $sformatf("R%04X", a) : $sformatf("R%04x", a);
      end
      case ($urandom_range(0, 2))
        0:       term = "\r";
        1:       term = "\n";
        default: term = "\r\n";
      endcase
      push_exp(a, rw ? d : 16'h0000, rw);
      send_str({s, term}, 3);
    end
    repeat (5) @(negedge clk);
    check_eq("t6_pulses", 32'(n_pulses), 32'd15);
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
